// File: rtl/pred_pkg.sv
// Shared branch-prediction types: instruction classes, BTB update record, queue default.
package pred_pkg;

    localparam int unsigned QDEPTH_DEF = 4;

    // Branch class encodings carried on ins_type; zero marks a non-branch.
    localparam logic [2:0] INS_NONE   = 3'b000;
    localparam logic [2:0] INS_COND   = 3'b001;
    localparam logic [2:0] INS_JAL    = 3'b010;
    localparam logic [2:0] INS_JALR   = 3'b011;
    localparam logic [2:0] INS_CALL   = 3'b100;
    localparam logic [2:0] INS_RET    = 3'b101;

    // One pending BTB correction.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic [2:0]  ins_type;
    } btb_update_t;

endpackage

// File: rtl/btb_update_queue_if.sv
// Resolve-side inputs (two execute slots) and the BTB update port of the update queue.
interface btb_update_queue_if #(
    parameter int unsigned DROPW = 8
);
    logic              res_valid_0;
    logic              res_valid_1;
    logic [31:0]       res_pc_0;
    logic [31:0]       res_pc_1;
    logic [2:0]        res_ins_type_0;
    logic [2:0]        res_ins_type_1;
    logic              res_pred_taken_0;
    logic              res_pred_taken_1;
    logic [31:0]       res_pred_target_0;
    logic [31:0]       res_pred_target_1;
    logic              res_act_taken_0;
    logic              res_act_taken_1;
    logic [31:0]       res_act_target_0;
    logic [31:0]       res_act_target_1;

    logic              branch_mistaken;
    logic [31:0]       wrong_pc;
    logic [31:0]       right_target;
    logic [2:0]        ins_type_w;
    logic              queue_full;
    logic [DROPW-1:0]  drop_count;

    // Execute stage side: drives resolutions, observes the BTB port.
    modport master (
        output res_valid_0, res_valid_1, res_pc_0, res_pc_1,
               res_ins_type_0, res_ins_type_1, res_pred_taken_0, res_pred_taken_1,
               res_pred_target_0, res_pred_target_1, res_act_taken_0, res_act_taken_1,
               res_act_target_0, res_act_target_1,
        input  branch_mistaken, wrong_pc, right_target, ins_type_w, queue_full, drop_count
    );

    // Queue side.
    modport slave (
        input  res_valid_0, res_valid_1, res_pc_0, res_pc_1,
               res_ins_type_0, res_ins_type_1, res_pred_taken_0, res_pred_taken_1,
               res_pred_target_0, res_pred_target_1, res_act_taken_0, res_act_taken_1,
               res_act_target_0, res_act_target_1,
        output branch_mistaken, wrong_pc, right_target, ins_type_w, queue_full, drop_count
    );

endinterface

// File: rtl/branch_check.sv
// Per-slot mispredict detection and BTB update entry formation.
module branch_check
    import pred_pkg::*;
(
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [2:0]  ins_type_i,
    input  logic        pred_taken_i,
    input  logic [31:0] pred_target_i,
    input  logic        act_taken_i,
    input  logic [31:0] act_target_i,
    output logic        mispredict_o,
    output btb_update_t entry_o
);

    // Target only matters when the branch was actually taken; fall-through wraps mod 2^32.
    always_comb begin
        mispredict_o = valid_i && (ins_type_i != INS_NONE) &&
                       ((pred_taken_i != act_taken_i) ||
                        (act_taken_i && (pred_target_i != act_target_i)));
        entry_o.pc       = pc_i;
        entry_o.target   = act_taken_i ? act_target_i : (pc_i + 32'd4);
        entry_o.ins_type = ins_type_i;
    end

endmodule

// File: rtl/btb_update_queue.sv
// Queues BTB corrections from two resolve slots and drains one per cycle into the BTB.
module btb_update_queue
    import pred_pkg::*;
#(
    parameter int unsigned QDEPTH = QDEPTH_DEF,
    parameter int unsigned DROPW  = 8
) (
    input  logic               clk,
    input  logic               reset,
    btb_update_queue_if.slave  bus
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    logic              mis0, mis1;
    btb_update_t       ent0, ent1;

    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DROPW-1:0]  drop_q, drop_d;
    btb_update_t       mem_q [QDEPTH];

    logic              empty, full, pop;
    logic [PW-1:0]     tail_idx;
    logic              enq_v;
    btb_update_t       enq_e;
    logic              coalesce, push, drop;

    branch_check u_chk0 (
        .valid_i       (bus.res_valid_0),
        .pc_i          (bus.res_pc_0),
        .ins_type_i    (bus.res_ins_type_0),
        .pred_taken_i  (bus.res_pred_taken_0),
        .pred_target_i (bus.res_pred_target_0),
        .act_taken_i   (bus.res_act_taken_0),
        .act_target_i  (bus.res_act_target_0),
        .mispredict_o  (mis0),
        .entry_o       (ent0)
    );

    branch_check u_chk1 (
        .valid_i       (bus.res_valid_1),
        .pc_i          (bus.res_pc_1),
        .ins_type_i    (bus.res_ins_type_1),
        .pred_taken_i  (bus.res_pred_taken_1),
        .pred_target_i (bus.res_pred_target_1),
        .act_taken_i   (bus.res_act_taken_1),
        .act_target_i  (bus.res_act_target_1),
        .mispredict_o  (mis1),
        .entry_o       (ent1)
    );

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(QDEPTH));
    // The BTB never back-pressures, so a non-empty head always retires.
    assign pop      = !empty;
    assign tail_idx = wr_ptr_q - PW'(1);

    // Slot 0 mispredicting flushes slot 1 as wrong-path, so slot 0 wins.
    always_comb begin
        enq_v = mis0 || mis1;
        enq_e = mis0 ? ent0 : ent1;
    end

    // Decide between coalesce, push and drop for the incoming entry.
    always_comb begin
        // A lone entry being popped this edge cannot be rewritten in place.
        coalesce = enq_v && !empty && (mem_q[tail_idx].pc == enq_e.pc) &&
                   !(pop && (count_q == CW'(1)));
        push     = enq_v && !coalesce && (!full || pop);
        drop     = enq_v && !coalesce && full && !pop;
    end

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + DROPW'(1);
        end
    end

    // Control state, cleared asynchronously so queued entries vanish at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Payload storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enq_e;
        end else if (coalesce) begin
            mem_q[tail_idx] <= enq_e;
        end
    end

    // Head drives the BTB port directly; zeros whenever the queue is empty.
    always_comb begin
        bus.branch_mistaken = !empty;
        bus.wrong_pc        = '0;
        bus.right_target    = '0;
        bus.ins_type_w      = '0;
        if (!empty) begin
            bus.wrong_pc     = mem_q[rd_ptr_q].pc;
            bus.right_target = mem_q[rd_ptr_q].target;
            bus.ins_type_w   = mem_q[rd_ptr_q].ins_type;
        end
        bus.queue_full = full;
        bus.drop_count = drop_q;
    end

endmodule

// File: doc/btb_update_queue.md
BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

Interface
REQ-001 SHALL have parameter QDEPTH, default 4: update-queue entries, power of two, at least 2.
REQ-002 SHALL have parameter DROPW, default 8: width of the drop counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports res_valid_0/1  input  1  resolved branch valid in execute, slot 0 older than slot 1.
REQ-006 SHALL have ports res_pc_0/1  input  32  branch PC.
REQ-007 SHALL have ports res_ins_type_0/1  input  3  branch class; 3'b000 means not a branch.
REQ-008 SHALL have ports res_pred_taken_0/1  input  1  fetch-time prediction (BTB hit).
REQ-009 SHALL have ports res_pred_target_0/1  input  32  predicted target.
REQ-010 SHALL have ports res_act_taken_0/1  input  1  resolved direction.
REQ-011 SHALL have ports res_act_target_0/1  input  32  resolved target.
REQ-012 SHALL have ports branch_mistaken  output  1, wrong_pc  output  32, right_target  output  32, ins_type_w  output  3: the BTB update port.
REQ-013 SHALL have port queue_full  output  1  occupancy == QDEPTH.
REQ-014 SHALL have port drop_count  output  DROPW  saturating count of dropped updates.

Function
REQ-015 A slot SHALL mispredict when res_valid && ins_type != 0 && (pred_taken != act_taken || (act_taken && pred_target != act_target)).
REQ-016 The update entry SHALL be {pc, act_taken ? act_target : pc+4 (mod 2^32), ins_type}.
REQ-017 If slot 0 mispredicts, slot 1 SHALL be ignored as wrong-path; otherwise slot 1 is checked alone. At most one enqueue per cycle.
REQ-018 Enqueue SHALL occur at the edge ending the resolve cycle; the head SHALL drive outputs combinationally, so an update into an empty queue appears in cycle N+1.
REQ-019 branch_mistaken SHALL equal queue non-empty; the BTB always accepts, so the head SHALL pop on every edge where branch_mistaken=1.
REQ-020 When empty, wrong_pc, right_target and ins_type_w SHALL be 0.
REQ-021 Coalesce: if the new pc equals the tail entry's pc and that tail is not being popped this edge, the tail SHALL be overwritten in place with no occupancy change.
REQ-022 Full with no pop: a new non-coalescing entry SHALL be dropped and drop_count incremented, saturating at all-ones. Full with a pop in the same edge: the entry SHALL be accepted.
REQ-023 Read and write pointers SHALL wrap modulo QDEPTH; occupancy SHALL be tracked in clog2(QDEPTH)+1 bits.
REQ-024 Occupancy SHALL never exceed QDEPTH or underflow.

Reset
REQ-025 Asserting reset SHALL asynchronously clear the pointers, occupancy and drop_count, forcing branch_mistaken=0, queue_full=0 and data outputs to 0.
REQ-026 Entries queued before a mid-operation reset SHALL be discarded, and no BTB write SHALL issue while reset is high.
REQ-027 Entry payload storage need not be reset.

Structure
REQ-028 Shared package pred_pkg SHALL hold the ins_type encodings, the btb_update_t struct {pc, target, ins_type} and the QDEPTH default.
REQ-029 The mispredict test and entry formation (REQ-015/016) SHALL be one sub-module, branch_check, instantiated once per slot. The FIFO SHALL stay inline.

Verification
REQ-030 Empty queue; slot 0 pc=0x1C000100, type=1, pred_taken=0, act_taken=1, act_target=0x1C000200 -> next cycle branch_mistaken=1, wrong_pc=0x1C000100, right_target=0x1C000200, ins_type_w=1; empty the cycle after.
REQ-031 Slot 0 pred_taken=1, act_taken=0, pc=0x1C000040 -> right_target=0x1C000044. Same cycle, slot 1 also mispredicts -> exactly one entry, slot 0's.
REQ-032 Slot 1 only mispredicts, pc=0x1C000300; slot 0 valid with a correct prediction -> one entry with wrong_pc=0x1C000300.
REQ-033 Queue full, then a mispredict arrives in a cycle with a pop -> accepted, no drop. Reach full and hold the head without popping (white-box force), then a new pc arrives -> drop_count 0 -> 1. Repeat 300 drops -> drop_count stays 255.
REQ-034 Two consecutive mispredicts with the same pc=0x1C000500 and targets 0x1C000600 then 0x1C000700, the tail not being popped -> a single entry with target 0x1C000700.
REQ-035 Assert reset mid-cycle with 3 entries queued -> branch_mistaken drops to 0 immediately without waiting for a clock edge; after release, nothing is emitted.
